arbitro_vc_switch: RTL and testbench
====================================

Name: arbitro_vc_switch

Overview:
- Control block for the 4-input / 4-output PCIe-style switch fabric.
- Drains four show-ahead input virtual-channel FIFOs into four output FIFOs (fifo4..fifo7), one word per transfer.
- Routes each word by its destination field, arbitrates round-robin among inputs, and back-pressures on the output FIFOs' almost_full.
- Sequences the configuration phase, latches the almost-full/almost-empty thresholds (umbrales) and distributes them to all FIFOs.

Parameters:
- TAMANO_DATOS, 12, word width; destination field is bits [9:8].
- UMBRALES_L_H, 8, width of the threshold values.
- CNT_W, 5, width of the per-output packet counters (optional feature only).

Ports:
- clk  in  1  fabric clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- init  in  1  1 = enter/stay in configuration.
- umbral_L_in  in  UMBRALES_L_H  almost-empty threshold to latch.
- umbral_H_in  in  UMBRALES_L_H  almost-full threshold to latch.
- in_empty  in  4  empty flags of input FIFOs 0..3.
- in_data0..in_data3  in  TAMANO_DATOS each  head word of each input FIFO (valid while !in_empty[i]).
- out_almost_full  in  4  almost_full flags of fifo4..fifo7 (bit d = fifo4+d).
- pop_in  out  4  one-hot pop to input FIFOs.
- push_out  out  4  one-hot push to output FIFOs.
- data_out  out  TAMANO_DATOS  word written to the pushed output FIFO.
- umbral_L  out  UMBRALES_L_H  active almost-empty threshold.
- umbral_H  out  UMBRALES_L_H  active almost-full threshold.
- cfg_err  out  1  last configuration attempt rejected.
- idle  out  1  state IDLE and all inputs empty.
- req  in  1  counter read request.
- idx  in  3  counter select; idx[1:0] = output d, idx[2] ignored.
- cnt_data  out  CNT_W  selected counter value.
- cnt_valid  out  1  cnt_data valid.

Behaviour:
- Reset (reset=0 at posedge) forces the following on the next edge, including mid-transfer:
  - state=RESET; pop_in=0, push_out=0, data_out=0.
  - umbral_L=0, umbral_H=0, cfg_err=0, idle=0.
  - rr_ptr=0; cnt_data=0, cnt_valid=0.
- FSM states: RESET, INIT, IDLE, ACTIVE.
  - RESET -> INIT when init=1; otherwise stay.
  - INIT: every cycle with init=1, latch the thresholds if umbral_L_in <= umbral_H_in and clear cfg_err; otherwise keep the previous values and set cfg_err=1.
  - INIT -> IDLE when init=0.
  - IDLE -> ACTIVE when any !in_empty.
  - ACTIVE -> IDLE when all in_empty=1 and no transfer is issued that cycle.
  - IDLE/ACTIVE -> INIT whenever init=1. No grants are made in INIT/RESET; a transfer already registered still completes that cycle.
- idle=1 only in IDLE with in_empty=4'hF, registered.
- Arbitration, evaluated each cycle in ACTIVE at edge N:
  - Candidate input i requires: !in_empty[i]; d = in_data_i[9:8]; !out_almost_full[d].
  - Input i is excluded if it was popped in the immediately preceding cycle (head not yet updated).
  - Destination d is excluded if it was pushed in the preceding cycle (almost_full lag).
  - Search order rr_ptr, rr_ptr+1, … mod 4; the first candidate wins.
- Transfer timing (registered, latency 1):
  - At edge N+1: pop_in[i]=1, push_out[d]=1, data_out = captured in_data_i. All three are valid during cycle N+1.
  - rr_ptr <= i+1 mod 4 on a grant; unchanged with no grant.
  - At most one transfer per cycle. pop_in and push_out are always both zero or both one-hot.
- Boundary cases:
  - Every candidate blocked by almost_full: no transfer, rr_ptr holds.
  - Two inputs targeting the same d: round-robin alternates between them, subject to the 1-cycle destination exclusion. Maximum throughput to one destination is therefore one word every 2 cycles.

Optional Feature:
- Macro: PKT_COUNT_EN.
- Defined:
  - One CNT_W counter per output, incremented on each push_out[d], saturating at 2^CNT_W-1.
  - Counters clear on reset and on entry to INIT.
  - When req=1 at edge N: cnt_data = counter[idx[1:0]] and cnt_valid=1 at N+1. req=0 gives cnt_valid=0 and cnt_data holds its value.
  - A read and an increment in the same cycle return the pre-increment value.
- Not defined: no counters; cnt_data=0 and cnt_valid=0 permanently; req and idx are ignored.

Test Plan:
- Config: reset=0 for 2 cycles, then init=1 with L=1/H=5 -> umbral_L=1, umbral_H=5, cfg_err=0. Then L=6/H=3 -> values stay 1/5 and cfg_err=1.
- Routing: input0 head 12'h0FB, input1 12'h1F6, input2 12'h2BB, input3 12'h3D7, all almost_full=0, rr_ptr=0 -> pushes to fifo4..fifo7 in order 0,1,2,3 on consecutive cycles; data_out matches each head.
- Back-pressure: out_almost_full[0]=1 with input0 head 12'h0FE -> no push_out[0]; input1 (dest 1) is served instead. Release almost_full -> input0 is popped within 2 cycles.
- Fairness: inputs 0 and 2 both hold dest-3 words (12'h7E1, 12'hBE1) continuously -> grants alternate 0,2,0,2 with one idle cycle between pushes to fifo7.
- Reset/init mid-traffic: assert reset=0 during a registered transfer -> next edge pop_in=push_out=0 and all counters 0. In a separate run, assert init=1 in ACTIVE -> no further grants until init=0 and the FSM returns to IDLE/ACTIVE.
- PKT_COUNT_EN: 3 words to fifo5, then req=1 with idx=3'b101 -> cnt_valid=1 and cnt_data=3 one cycle later. Push 40 words to fifo4 -> its counter saturates at 31.

Source files
------------

// File: rtl/arbitro_vc_switch.sv
// Switch-fabric control: drains four input VC FIFOs into fifo4..fifo7 with round-robin arbitration.
// Optional per-output packet counters are built when PKT_COUNT_EN is defined.
module arbitro_vc_switch #(
    parameter int TAMANO_DATOS = 12,
    parameter int UMBRALES_L_H = 8,
    parameter int CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRALES_L_H-1:0] umbral_L_in,
    input  logic [UMBRALES_L_H-1:0] umbral_H_in,
    input  logic [3:0]              in_empty,
    input  logic [TAMANO_DATOS-1:0] in_data0,
    input  logic [TAMANO_DATOS-1:0] in_data1,
    input  logic [TAMANO_DATOS-1:0] in_data2,
    input  logic [TAMANO_DATOS-1:0] in_data3,
    input  logic [3:0]              out_almost_full,
    output logic [3:0]              pop_in,
    output logic [3:0]              push_out,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic [UMBRALES_L_H-1:0] umbral_L,
    output logic [UMBRALES_L_H-1:0] umbral_H,
    output logic                    cfg_err,
    output logic                    idle,
    input  logic                    req,
    input  logic [2:0]              idx,
    output logic [CNT_W-1:0]        cnt_data,
    output logic                    cnt_valid
);

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              rr_ptr;
    logic                    gnt_valid;
    logic [1:0]              gnt_src;
    logic [1:0]              gnt_dst;
    logic [TAMANO_DATOS-1:0] gnt_word;
    logic [1:0]              cand_src;
    logic [1:0]              cand_dst;
    logic [TAMANO_DATOS-1:0] head [4];

    assign head[0] = in_data0;
    assign head[1] = in_data1;
    assign head[2] = in_data2;
    assign head[3] = in_data3;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET:  if (init) state_next = ST_INIT;
            ST_INIT:   if (!init) state_next = ST_IDLE;
            ST_IDLE: begin
                if (init)              state_next = ST_INIT;
                else if (!(&in_empty)) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                         state_next = ST_INIT;
                else if ((&in_empty) && !gnt_valid) state_next = ST_IDLE;
            end
            default: state_next = ST_RESET;
        endcase
    end

    // Registered pop/push lag the FIFO flags by a cycle, so last cycle's source and destination sit out.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = '0;
        gnt_dst   = '0;
        gnt_word  = '0;
        cand_src  = '0;
        cand_dst  = '0;
        if (state == ST_ACTIVE && !init) begin
            for (int k = 0; k < 4; k++) begin
                cand_src = rr_ptr + 2'(k);
                cand_dst = head[cand_src][9:8];
                if (!gnt_valid && !in_empty[cand_src] && !pop_in[cand_src] &&
                    !push_out[cand_dst] && !out_almost_full[cand_dst]) begin
                    gnt_valid = 1'b1;
                    gnt_src   = cand_src;
                    gnt_dst   = cand_dst;
                    gnt_word  = head[cand_src];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_in   <= '0;
            push_out <= '0;
            data_out <= '0;
            rr_ptr   <= '0;
            umbral_L <= '0;
            umbral_H <= '0;
            cfg_err  <= 1'b0;
            idle     <= 1'b0;
        end else begin
            pop_in   <= gnt_valid ? (4'b0001 << gnt_src) : 4'b0000;
            push_out <= gnt_valid ? (4'b0001 << gnt_dst) : 4'b0000;
            data_out <= gnt_valid ? gnt_word : '0;
            if (gnt_valid) rr_ptr <= gnt_src + 2'd1;
            if (state == ST_INIT && init) begin
                if (umbral_L_in <= umbral_H_in) begin
                    umbral_L <= umbral_L_in;
                    umbral_H <= umbral_H_in;
                    cfg_err  <= 1'b0;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end
            idle <= (state == ST_IDLE) && (&in_empty);
        end
    end

`ifdef PKT_COUNT_EN
    logic [CNT_W-1:0] pkt_cnt [4];
    logic             cnt_clear;
    logic             unused_idx;

    assign cnt_clear  = (state != ST_INIT) && (state_next == ST_INIT);
    assign unused_idx = idx[2];

    always_ff @(posedge clk) begin
        if (!reset || cnt_clear) begin
            for (int d = 0; d < 4; d++) pkt_cnt[d] <= '0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (push_out[d] && pkt_cnt[d] != {CNT_W{1'b1}}) pkt_cnt[d] <= pkt_cnt[d] + CNT_W'(1);
            end
        end
    end

    // A read races an increment by sampling the counter before the edge updates it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_data  <= '0;
            cnt_valid <= 1'b0;
        end else if (req) begin
            cnt_data  <= pkt_cnt[idx[1:0]];
            cnt_valid <= 1'b1;
        end else begin
            cnt_valid <= 1'b0;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^{req, idx};
    assign cnt_data   = '0;
    assign cnt_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_vc_switch.sv
// Bench for arbitro_vc_switch: queue-based input FIFOs, a rule-level reference model checked every cycle,
// and directed phases with literal expectations.
module tb_arbitro_vc_switch;

    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0;
    logic [7:0]  umbral_L_in = '0, umbral_H_in = '0;
    logic [3:0]  in_empty = 4'hF;
    logic [11:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic [3:0]  out_almost_full = '0;
    logic [3:0]  pop_in, push_out;
    logic [11:0] data_out;
    logic [7:0]  umbral_L, umbral_H;
    logic        cfg_err, idle;
    logic        req = 1'b0;
    logic [2:0]  idx = '0;
    logic [4:0]  cnt_data;
    logic        cnt_valid;

    int n_checks = 0;
    int n_pass   = 0;

    arbitro_vc_switch dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_L_in(umbral_L_in), .umbral_H_in(umbral_H_in),
        .in_empty(in_empty),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .out_almost_full(out_almost_full),
        .pop_in(pop_in), .push_out(push_out), .data_out(data_out),
        .umbral_L(umbral_L), .umbral_H(umbral_H), .cfg_err(cfg_err), .idle(idle),
        .req(req), .idx(idx), .cnt_data(cnt_data), .cnt_valid(cnt_valid)
    );

    always #5 clk = ~clk;

    // Input FIFOs as queues; the head is presented show-ahead.
    logic [11:0] fq0[$], fq1[$], fq2[$], fq3[$];
    logic [3:0]  pend_pop = '0;

    task automatic drive_heads();
        in_empty[0] = (fq0.size() == 0); in_data0 = (fq0.size() != 0) ? fq0[0] : 12'h000;
        in_empty[1] = (fq1.size() == 0); in_data1 = (fq1.size() != 0) ? fq1[0] : 12'h000;
        in_empty[2] = (fq2.size() == 0); in_data2 = (fq2.size() != 0) ? fq2[0] : 12'h000;
        in_empty[3] = (fq3.size() == 0); in_data3 = (fq3.size() != 0) ? fq3[0] : 12'h000;
    endtask

    task automatic load(input int i, input logic [11:0] w);
        case (i)
            0: fq0.push_back(w);
            1: fq1.push_back(w);
            2: fq2.push_back(w);
            default: fq3.push_back(w);
        endcase
        drive_heads();
    endtask

    always @(negedge clk) pend_pop = pop_in;

    always @(posedge clk) begin
        #1;
        if (pend_pop[0] === 1'b1 && fq0.size() != 0) void'(fq0.pop_front());
        if (pend_pop[1] === 1'b1 && fq1.size() != 0) void'(fq1.pop_front());
        if (pend_pop[2] === 1'b1 && fq2.size() != 0) void'(fq2.pop_front());
        if (pend_pop[3] === 1'b1 && fq3.size() != 0) void'(fq3.pop_front());
        pend_pop = '0;
        drive_heads();
    end

    // Reference model: state and expected registered outputs, derived from the rules.
    int          cyc = 0;
    bit          m_live = 0;
    int          m_st = M_RESET;
    int          m_rr = 0;
    logic [3:0]  m_pop = '0, m_push = '0;
    logic [11:0] m_data = '0;
    logic [7:0]  m_L = '0, m_H = '0;
    logic        m_err = 0, m_idle = 0;
    int          m_cnt[4] = '{0, 0, 0, 0};
    logic [4:0]  m_cdata = '0;
    logic        m_cvalid = 0;

    int          log_cyc[$];
    logic [3:0]  log_pop[$], log_push[$];
    logic [11:0] log_data[$];

    task automatic clear_log();
        log_cyc.delete(); log_pop.delete(); log_push.delete(); log_data.delete();
    endtask

    always @(posedge clk) begin
        logic        s_reset, s_init, s_req;
        logic [3:0]  s_empty, s_af;
        logic [11:0] s_data[4];
        logic [7:0]  s_L, s_H;
        logic [2:0]  s_idx;
        int          win, nxt, d;
        logic [43:0] exp_v, act_v;
        s_reset = reset; s_init = init; s_req = req; s_idx = idx;
        s_empty = in_empty; s_af = out_almost_full;
        s_data[0] = in_data0; s_data[1] = in_data1; s_data[2] = in_data2; s_data[3] = in_data3;
        s_L = umbral_L_in; s_H = umbral_H_in;
        cyc++;
        if (!s_reset) begin
            m_live = 1; m_st = M_RESET; m_rr = 0; m_pop = '0; m_push = '0; m_data = '0;
            m_L = '0; m_H = '0; m_err = 0; m_idle = 0; m_cdata = '0; m_cvalid = 0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (m_live) begin
            win = -1;
            if (m_st == M_ACTIVE && !s_init) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_rr + k) % 4;
                    d = int'(s_data[i][9:8]);
                    if (win < 0 && !s_empty[i] && !m_pop[i] && !m_push[d] && !s_af[d]) win = i;
                end
            end
            case (m_st)
                M_RESET: nxt = s_init ? M_INIT : M_RESET;
                M_INIT:  nxt = s_init ? M_INIT : M_IDLE;
                M_IDLE:  nxt = s_init ? M_INIT : (s_empty != 4'hF ? M_ACTIVE : M_IDLE);
                default: nxt = s_init ? M_INIT : ((s_empty == 4'hF && win < 0) ? M_IDLE : M_ACTIVE);
            endcase
`ifdef PKT_COUNT_EN
            if (s_req) begin m_cdata = 5'(m_cnt[s_idx[1:0]]); m_cvalid = 1; end
            else m_cvalid = 0;
            for (int k = 0; k < 4; k++) if (m_push[k] && m_cnt[k] < 31) m_cnt[k]++;
            if (nxt == M_INIT && m_st != M_INIT) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
`endif
            if (m_st == M_INIT && s_init) begin
                if (s_L <= s_H) begin m_L = s_L; m_H = s_H; m_err = 0; end
                else m_err = 1;
            end
            m_idle = (m_st == M_IDLE) && (s_empty == 4'hF);
            if (win >= 0) begin
                d = int'(s_data[win][9:8]);
                m_pop = 4'b0001 << win; m_push = 4'b0001 << d; m_data = s_data[win];
                m_rr = (win + 1) % 4;
            end else begin
                m_pop = '0; m_push = '0; m_data = '0;
            end
            m_st = nxt;
        end
        #2;
        if (m_live) begin
            exp_v = {m_pop, m_push, m_data, m_L, m_H, m_err, m_idle, m_cdata, m_cvalid};
            act_v = {pop_in, push_out, data_out, umbral_L, umbral_H, cfg_err, idle, cnt_data, cnt_valid};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL cycle_outputs cyc=%0d got pop=%h push=%h data=%h L=%h H=%h err=%b idle=%b cnt=%0d cv=%b expected pop=%h push=%h data=%h L=%h H=%h err=%b idle=%b cnt=%0d cv=%b",
                          cyc, pop_in, push_out, data_out, umbral_L, umbral_H, cfg_err, idle, cnt_data, cnt_valid,
                          m_pop, m_push, m_data, m_L, m_H, m_err, m_idle, m_cdata, m_cvalid);
            if (push_out !== 4'b0000) begin
                log_cyc.push_back(cyc); log_pop.push_back(pop_in);
                log_push.push_back(push_out); log_data.push_back(data_out);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", name, act, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [11:0] route_w[4];
    int          remaining;
    bit          seen;

    initial begin
        route_w[0] = 12'h0FB; route_w[1] = 12'h1F6; route_w[2] = 12'h2BB; route_w[3] = 12'h3D7;
        drive_heads();

        // Reset held for two edges: everything cleared.
        wait_cycles(2);
        check("rst_pop", 32'(pop_in), 0);
        check("rst_push", 32'(push_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_thresh", {16'h0, umbral_L, umbral_H}, 0);
        check("rst_err_idle", {30'h0, cfg_err, idle}, 0);
        check("rst_cnt", {26'h0, cnt_data, cnt_valid}, 0);

        // Configuration: valid pair latches, inverted pair is rejected.
        reset = 1; init = 1; umbral_L_in = 8'd1; umbral_H_in = 8'd5;
        wait_cycles(3);
        check("cfg_ok", {15'h0, umbral_L, umbral_H, cfg_err}, {15'h0, 8'd1, 8'd5, 1'b0});
        umbral_L_in = 8'd6; umbral_H_in = 8'd3;
        wait_cycles(2);
        check("cfg_bad", {15'h0, umbral_L, umbral_H, cfg_err}, {15'h0, 8'd1, 8'd5, 1'b1});
        init = 0;
        wait_cycles(3);
        check("idle_after_cfg", 32'(idle), 1);

        // Routing: one word per input, each to its own output, served 0..3 back to back.
        clear_log();
        for (int i = 0; i < 4; i++) load(i, route_w[i]);
        wait_cycles(10);
        check("route_count", log_cyc.size(), 4);
        for (int j = 0; j < 4 && j < log_cyc.size(); j++) begin
            check($sformatf("route_pop%0d", j), 32'(log_pop[j]), 32'(4'b0001 << j));
            check($sformatf("route_push%0d", j), 32'(log_push[j]), 32'(4'b0001 << j));
            check($sformatf("route_data%0d", j), 32'(log_data[j]), 32'(route_w[j]));
            if (j > 0) check($sformatf("route_gap%0d", j), log_cyc[j] - log_cyc[j-1], 1);
        end
        check("idle_after_route", 32'(idle), 1);

        // Back-pressure on fifo4: input1 goes instead, input0 follows once released.
        out_almost_full = 4'b0001;
        clear_log();
        load(0, 12'h0FE); load(1, 12'h1A5);
        wait_cycles(6);
        check("bp_count", log_cyc.size(), 1);
        if (log_cyc.size() > 0) begin
            check("bp_push", 32'(log_push[0]), 32'(4'b0010));
            check("bp_data", 32'(log_data[0]), 32'h1A5);
        end
        out_almost_full = 4'b0000;
        clear_log();
        seen = 0;
        for (int t = 0; t < 2 && !seen; t++) begin
            @(negedge clk);
            if (log_cyc.size() > 0) seen = 1;
        end
        check("bp_release_seen", 32'(seen), 1);
        if (seen) check("bp_release", {16'h0, log_push[0], log_data[0]}, {16'h0, 4'b0001, 12'h0FE});
        wait_cycles(4);

        // Fairness: inputs 0 and 2 both aim at fifo7; rr_ptr is 1 here so input 2 leads.
        clear_log();
        for (int j = 0; j < 4; j++) begin load(0, 12'h7E1); load(2, 12'hBE1); end
        wait_cycles(22);
        check("fair_count", log_cyc.size(), 8);
        if (log_cyc.size() > 0) check("fair_first", 32'(log_data[0]), 32'hBE1);
        for (int j = 1; j < log_cyc.size(); j++) begin
            check($sformatf("fair_gap%0d", j), log_cyc[j] - log_cyc[j-1], 2);
            check($sformatf("fair_alt%0d", j), 32'(log_data[j]), (log_data[j-1] == 12'h7E1) ? 32'hBE1 : 32'h7E1);
            check($sformatf("fair_push%0d", j), 32'(log_push[j]), 32'(4'b1000));
        end

        // Counters: clear through INIT, three words to fifo5, then read via idx=3'b101.
        init = 1; wait_cycles(2); init = 0; wait_cycles(3);
        load(1, 12'h100); load(1, 12'h101); load(1, 12'h102);
        wait_cycles(10);
        req = 1; idx = 3'b101;
        wait_cycles(1);
        req = 0;
`ifdef PKT_COUNT_EN
        check("cnt_fifo5", {26'h0, cnt_data, cnt_valid}, {26'h0, 5'd3, 1'b1});
`else
        check("cnt_fifo5_off", {26'h0, cnt_data, cnt_valid}, 0);
`endif
        for (int j = 0; j < 40; j++) load(0, 12'(j));
        wait_cycles(100);
        req = 1; idx = 3'b000;
        wait_cycles(1);
        req = 0;
`ifdef PKT_COUNT_EN
        check("cnt_fifo4_sat", {26'h0, cnt_data, cnt_valid}, {26'h0, 5'd31, 1'b1});
`else
        check("cnt_fifo4_off", {26'h0, cnt_data, cnt_valid}, 0);
`endif
        wait_cycles(1);
        check("cnt_valid_drop", 32'(cnt_valid), 0);

        // init in ACTIVE freezes grants until released.
        for (int j = 0; j < 6; j++) begin load(0, 12'h2C0 + 12'(j)); load(1, 12'h3C0 + 12'(j)); end
        wait_cycles(4);
        init = 1;
        wait_cycles(1);
        clear_log();
        remaining = fq0.size() + fq1.size();
        wait_cycles(5);
        check("init_freeze", log_cyc.size(), 0);
        init = 0;
        wait_cycles(30);
        check("init_resume", log_cyc.size(), remaining);

        // Reset during a registered transfer.
        for (int j = 0; j < 6; j++) begin load(0, 12'h1E0 + 12'(j)); load(2, 12'h2E0 + 12'(j)); end
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (push_out !== 4'b0000) seen = 1;
        end
        check("midrst_transfer_seen", 32'(seen), 1);
        reset = 0;
        wait_cycles(1);
        check("midrst_pop_push", {24'h0, pop_in, push_out}, 0);
        check("midrst_cnt", {26'h0, cnt_data, cnt_valid}, 0);
        fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
        drive_heads();
        wait_cycles(1);
        reset = 1;
        wait_cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
